controller_poller_m: RTL and testbench
======================================

# controller_poller_m

Console-side master for the serial game-controller protocol: drives the shared latch and controller clock, shifts in two active-low data lines, and presents the two decoded button bytes to the CPU-facing register file. It sits in the controller interface, between the memory-mapped I/O block and the external (or simulated) controller shift registers. One poll is triggered per strobe, normally once per frame from vsync.

## Interface
- HALF_PERIOD, default 6: system clock cycles per controller-clock half period; legal range ≥1.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- poll  in  1  one-cycle start strobe. Ignored unless idle.
- data_1_B  in  1  serial data from controller 1, active-low.
- data_2_B  in  1  serial data from controller 2, active-low.
- latch  out  1  shared latch to both controllers; registered.
- ctrl_clk  out  1  shared controller clock level; registered.
- ctrl_clk_en  out  1  one-cycle strobe, high in the same cycle `ctrl_clk` rises. Used by same-clock-domain controllers.
- buttons_1  out  8  controller 1 state, active-high pressed, {a,b,select,start,up,down,left,right}.
- buttons_2  out  8  controller 2 state, same layout.
- valid  out  1  one-cycle pulse when `buttons_*` update.
- busy  out  1  high from the cycle after an accepted `poll` through the `valid` cycle.

## Operation
- Half-period tick: a counter of width max(1,$clog2(HALF_PERIOD)) runs only while busy. It ticks every HALF_PERIOD cycles and reloads when a poll is accepted.
- FSM states are IDLE, LATCH, SHIFT_LO, SHIFT_HI and DONE.
  - IDLE: `latch`=0, `ctrl_clk`=0. A `poll` moves the FSM to LATCH and clears the bit counter.
  - LATCH lasts 2 half periods with `latch`=1.
    - `ctrl_clk` is 0 in the first half and 1 in the second half. `ctrl_clk_en` fires at that rise, so controllers with synchronous latch capture on it.
    - At the end of the second half, `latch` and `ctrl_clk` fall together and the FSM moves to SHIFT_LO.
  - SHIFT_LO lasts 1 half period with `ctrl_clk`=0. On its final cycle it samples `~data_1_B` and `~data_2_B` into shift registers, MSB first, then moves to SHIFT_HI.
  - SHIFT_HI lasts 1 half period. `ctrl_clk`=1 and `ctrl_clk_en` fires on entry.
    - On exit, if bit counter = 7, the FSM moves to DONE.
    - Otherwise it increments the 3-bit counter and moves to SHIFT_LO.
  - DONE lasts 1 cycle: copy the shift registers to `buttons_1`/`buttons_2`, pulse `valid`, then go to IDLE.
- Bit mapping: the first sampled bit becomes bit 7 (a); the eighth becomes bit 0 (right).
- 8 rising controller-clock edges follow the latch. The trailing 8th edge is harmless.
- Disconnected controller (line floats high) reads 8'h00.
- `buttons_*` hold their value between polls and change only in DONE.

## Timing
- `poll` accepted at cycle 0 → `latch` and `busy` high at cycle 1.
- `valid` is high at cycle 18·HALF_PERIOD+1; `busy` falls at cycle 18·HALF_PERIOD+2.
- Sample k (k=0..7) is taken at cycle 2·HALF_PERIOD + (2k+1)·HALF_PERIOD, on the last cycle of its low phase. This gives a full half period for data to settle after the preceding rising edge.
- A `poll` on the DONE cycle is ignored. A `poll` in the first IDLE cycle after DONE is accepted.
- Reset values: `latch`=0, `ctrl_clk`=0, `ctrl_clk_en`=0, `buttons_1`=`buttons_2`=8'h00, `valid`=0, `busy`=0, FSM=IDLE.
- Reset mid-poll aborts immediately, giving reset values on the next cycle. Partial samples are discarded.
- `rst` and `poll` in the same cycle: reset wins.

## Structure
- Shared package `controller_interface_pkg` holds:
  - the state enum `poller_state_t`;
  - button bit-index localparams BTN_A=7 … BTN_RIGHT=0, shared with the controller model and the MMIO decoder.
- One natural sub-module: `controller_tick_m`, the half-period divider with a reload input and a `tick` output.
- The FSM, bit counter and shift registers stay in `controller_poller_m`.

## Test plan
- HALF_PERIOD=6, both controllers are models with SYNC_LATCH=0, buttons_B=8'b0111_1110 and 8'b1111_1111 → `valid` at cycle 109 with `buttons_1`=8'h81, `buttons_2`=8'h00.
- Same stimulus with SYNC_LATCH=1 models clocked on `clk` using `ctrl_clk_en` → identical result and timing.
- HALF_PERIOD=1, controller 2 pressing only up → `buttons_2`=8'h08 at cycle 19; count exactly 8 `ctrl_clk` rises after `latch` falls.
- `poll` repeated every cycle while busy → exactly one `valid` per 18·HALF_PERIOD+2 cycles; no extra latch pulses.
- `rst` asserted at cycle 40 of a poll → next cycle all outputs at reset values. A fresh poll then returns the correct bytes.
- Buttons change between two polls (8'hFE then 8'hFF on buttons_B) → `buttons_1` goes 8'h01 to 8'h00. It is stable between `valid` pulses.

Source files
------------

// File: rtl/controller_interface_pkg.sv
// Shared definitions for the serial game-controller interface: poller FSM states,
// button bit positions and payload widths.
package controller_interface_pkg;

  localparam int unsigned BTN_W     = 8;
  localparam int unsigned BIT_CNT_W = 3;

  // Button bit positions inside a decoded byte, first shifted bit is the MSB.
  localparam int unsigned BTN_A      = 7;
  localparam int unsigned BTN_B      = 6;
  localparam int unsigned BTN_SELECT = 5;
  localparam int unsigned BTN_START  = 4;
  localparam int unsigned BTN_UP     = 3;
  localparam int unsigned BTN_DOWN   = 2;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_RIGHT  = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_DONE     = 3'd4
  } poller_state_t;

  typedef struct packed {
    logic a;
    logic b;
    logic select;
    logic start;
    logic up;
    logic down;
    logic left;
    logic right;
  } buttons_t;

endpackage

// File: rtl/controller_tick_m.sv
// Half-period divider for the controller clock: tick is high on the last system
// cycle of every half period while running, restarting from zero on reload.
module controller_tick_m #(
  parameter int unsigned HALF_PERIOD = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_d;

  // Tick is registered, so it is derived from the count the next cycle will hold.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (reload) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
    tick_d = (reload || run) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= tick_d;
    end
  end

endmodule

// File: rtl/controller_poller_m.sv
// Console-side poller: latches both controllers, clocks out eight bits from each
// active-low data line and publishes the decoded button bytes with a valid pulse.
module controller_poller_m #(
  parameter int unsigned HALF_PERIOD = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll,
  input  logic       data_1_B,
  input  logic       data_2_B,
  output logic       latch,
  output logic       ctrl_clk,
  output logic       ctrl_clk_en,
  output logic [7:0] buttons_1,
  output logic [7:0] buttons_2,
  output logic       valid,
  output logic       busy
);

  import controller_interface_pkg::*;

  poller_state_t        state_q;
  logic                 latch_q;
  logic                 ctrl_clk_q;
  logic                 ctrl_clk_en_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 half_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [BTN_W-1:0]     shift_1_q;
  logic [BTN_W-1:0]     shift_2_q;
  logic [BTN_W-1:0]     buttons_1_q;
  logic [BTN_W-1:0]     buttons_2_q;
  logic                 tick;
  logic                 poll_accept_c;

  assign poll_accept_c = poll && (state_q == ST_IDLE);

  controller_tick_m #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .reload (poll_accept_c),
    .run    (busy_q),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      latch_q       <= 1'b0;
      ctrl_clk_q    <= 1'b0;
      ctrl_clk_en_q <= 1'b0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      half_q        <= 1'b0;
      bit_cnt_q     <= '0;
      shift_1_q     <= '0;
      shift_2_q     <= '0;
      buttons_1_q   <= '0;
      buttons_2_q   <= '0;
    end else begin
      ctrl_clk_en_q <= 1'b0;
      valid_q       <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (poll) begin
            state_q   <= ST_LATCH;
            latch_q   <= 1'b1;
            busy_q    <= 1'b1;
            half_q    <= 1'b0;
            bit_cnt_q <= '0;
            shift_1_q <= '0;
            shift_2_q <= '0;
          end
        end
        ST_LATCH: begin
          // Clock rises mid-latch so synchronous-latch controllers capture on it.
          if (tick) begin
            if (!half_q) begin
              half_q        <= 1'b1;
              ctrl_clk_q    <= 1'b1;
              ctrl_clk_en_q <= 1'b1;
            end else begin
              latch_q    <= 1'b0;
              ctrl_clk_q <= 1'b0;
              state_q    <= ST_SHIFT_LO;
            end
          end
        end
        ST_SHIFT_LO: begin
          // Sample at the end of the low phase, a full half period after the last rise.
          if (tick) begin
            shift_1_q[BIT_CNT_W'(BTN_A) - bit_cnt_q] <= ~data_1_B;
            shift_2_q[BIT_CNT_W'(BTN_A) - bit_cnt_q] <= ~data_2_B;
            ctrl_clk_q    <= 1'b1;
            ctrl_clk_en_q <= 1'b1;
            state_q       <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (tick) begin
            ctrl_clk_q <= 1'b0;
            if (bit_cnt_q == BIT_CNT_W'(BTN_A - BTN_RIGHT)) begin
              // Button registers and valid become visible together in DONE.
              buttons_1_q <= shift_1_q;
              buttons_2_q <= shift_2_q;
              valid_q     <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
              state_q   <= ST_SHIFT_LO;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          latch_q    <= 1'b0;
          ctrl_clk_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign latch       = latch_q;
  assign ctrl_clk    = ctrl_clk_q;
  assign ctrl_clk_en = ctrl_clk_en_q;
  assign buttons_1   = buttons_1_q;
  assign buttons_2   = buttons_2_q;
  assign valid       = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_controller_poller_m.sv
// Directed bench for controller_poller_m: two instances (HALF_PERIOD 6 and 1)
// driven by behavioural controller shift registers.
module tb_controller_poller_m;

  import controller_interface_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       poll6 = 1'b0;
  logic       poll1 = 1'b0;
  logic       sync6 = 1'b0;
  logic [7:0] btn6_1_B = 8'hFF;
  logic [7:0] btn6_2_B = 8'hFF;
  logic [7:0] btn1_1_B = 8'hFF;
  logic [7:0] btn1_2_B = 8'hFF;

  logic       d6_1_B, d6_2_B, d1_1_B, d1_2_B;
  logic       latch6, cclk6, cen6, valid6, busy6;
  logic       latch1, cclk1, cen1, valid1, busy1;
  logic [7:0] b6_1, b6_2, b1_1, b1_2;

  logic [7:0] sra6_1 = 8'hFF, sra6_2 = 8'hFF;
  logic [7:0] srs6_1 = 8'hFF, srs6_2 = 8'hFF;
  logic [7:0] sra1_1 = 8'hFF, sra1_2 = 8'hFF;

  int cyc  = 0;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  controller_poller_m #(.HALF_PERIOD(6)) dut6 (
    .clk(clk), .rst(rst), .poll(poll6), .data_1_B(d6_1_B), .data_2_B(d6_2_B),
    .latch(latch6), .ctrl_clk(cclk6), .ctrl_clk_en(cen6),
    .buttons_1(b6_1), .buttons_2(b6_2), .valid(valid6), .busy(busy6)
  );

  controller_poller_m #(.HALF_PERIOD(1)) dut1 (
    .clk(clk), .rst(rst), .poll(poll1), .data_1_B(d1_1_B), .data_2_B(d1_2_B),
    .latch(latch1), .ctrl_clk(cclk1), .ctrl_clk_en(cen1),
    .buttons_1(b1_1), .buttons_2(b1_2), .valid(valid1), .busy(busy1)
  );

  // Controllers with asynchronous latch: load on latch, shift on ctrl_clk rise.
  always @(posedge cclk6 or posedge latch6) begin
    if (latch6) begin
      sra6_1 <= btn6_1_B;
      sra6_2 <= btn6_2_B;
    end else begin
      sra6_1 <= {sra6_1[6:0], 1'b1};
      sra6_2 <= {sra6_2[6:0], 1'b1};
    end
  end

  always @(posedge cclk1 or posedge latch1) begin
    if (latch1) begin
      sra1_1 <= btn1_1_B;
      sra1_2 <= btn1_2_B;
    end else begin
      sra1_1 <= {sra1_1[6:0], 1'b1};
      sra1_2 <= {sra1_2[6:0], 1'b1};
    end
  end

  // Controllers clocked on clk, acting only on the ctrl_clk_en strobe.
  always @(posedge clk) begin
    if (cen6) begin
      if (latch6) begin
        srs6_1 <= btn6_1_B;
        srs6_2 <= btn6_2_B;
      end else begin
        srs6_1 <= {srs6_1[6:0], 1'b1};
        srs6_2 <= {srs6_2[6:0], 1'b1};
      end
    end
  end

  assign d6_1_B = sync6 ? srs6_1[7] : sra6_1[7];
  assign d6_2_B = sync6 ? srs6_2[7] : sra6_2[7];
  assign d1_1_B = sra1_1[7];
  assign d1_2_B = sra1_2[7];

  // Pulses poll6 for one cycle; returns with the bench at cycle 1 of the poll.
  task automatic start6(output int p0);
    poll6 = 1'b1;
    p0 = cyc;
    @(negedge clk);
    poll6 = 1'b0;
  endtask

  task automatic wait_valid6(input int p0, input int budget, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      if (valid6) begin
        ok = 1'b1;
        at = cyc - p0;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if ({latch6, cclk6, cen6, valid6, busy6} !== 5'b0) begin
      errs++;
      $display("FAIL reset_ctrl6: got %b expected 00000", {latch6, cclk6, cen6, valid6, busy6});
    end
    vecs++;
    if ({b6_1, b6_2} !== 16'h0000) begin
      errs++;
      $display("FAIL reset_buttons6: got %h expected 0000", {b6_1, b6_2});
    end
    vecs++;
    if ({latch1, cclk1, cen1, valid1, busy1, b1_1, b1_2} !== 21'h0) begin
      errs++;
      $display("FAIL reset_dut1: got %h expected 000000", {latch1, cclk1, cen1, valid1, busy1, b1_1, b1_2});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_poll_async();
    int p0, at;
    bit ok;
    sync6 = 1'b0;
    btn6_1_B = 8'b0111_1110;
    btn6_2_B = 8'b1111_1111;
    start6(p0);
    vecs++;
    if ({latch6, busy6, cclk6} !== 3'b110) begin
      errs++;
      $display("FAIL async_cycle1: got latch,busy,clk=%b expected 110", {latch6, busy6, cclk6});
    end
    wait_valid6(p0, 200, at, ok);
    vecs++;
    if (!ok || at != 109) begin
      errs++;
      $display("FAIL async_valid_cycle: got %0d expected 109", at);
    end
    vecs++;
    if (b6_1 !== 8'h81 || b6_2 !== 8'h00) begin
      errs++;
      $display("FAIL async_buttons: got %h/%h expected 81/00", b6_1, b6_2);
    end
    @(negedge clk);
    vecs++;
    if ({busy6, valid6} !== 2'b00) begin
      errs++;
      $display("FAIL async_busy_fall: got busy,valid=%b expected 00", {busy6, valid6});
    end
  endtask

  task automatic test_poll_sync();
    int p0, at;
    bit ok;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sync6 = 1'b1;
    btn6_1_B = 8'b0111_1110;
    btn6_2_B = 8'b1111_1111;
    start6(p0);
    wait_valid6(p0, 200, at, ok);
    vecs++;
    if (!ok || at != 109) begin
      errs++;
      $display("FAIL sync_valid_cycle: got %0d expected 109", at);
    end
    vecs++;
    if (b6_1 !== 8'h81 || b6_2 !== 8'h00) begin
      errs++;
      $display("FAIL sync_buttons: got %h/%h expected 81/00", b6_1, b6_2);
    end
    @(negedge clk);
    sync6 = 1'b0;
  endtask

  task automatic test_half_period_one();
    int p0, at, rises;
    bit ok, fell;
    logic prev;
    btn1_1_B = 8'hFF;
    btn1_2_B = ~(8'h01 << BTN_UP);
    poll1 = 1'b1;
    p0 = cyc;
    @(negedge clk);
    poll1 = 1'b0;
    ok = 1'b0;
    fell = 1'b0;
    rises = 0;
    at = -1;
    prev = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (fell && cclk1 && !prev) rises++;
      if (!latch1) fell = 1'b1;
      prev = cclk1;
      if (valid1) begin
        ok = 1'b1;
        at = cyc - p0;
      end else begin
        @(negedge clk);
      end
    end
    vecs++;
    if (!ok || at != 19) begin
      errs++;
      $display("FAIL hp1_valid_cycle: got %0d expected 19", at);
    end
    vecs++;
    if (b1_2 !== 8'h08 || b1_1 !== 8'h00) begin
      errs++;
      $display("FAIL hp1_buttons: got %h/%h expected 00/08", b1_1, b1_2);
    end
    vecs++;
    if (rises != 8) begin
      errs++;
      $display("FAIL hp1_clk_rises: got %0d expected 8", rises);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int p0, nvalid, nlatch, n;
    int vat[4];
    logic prev_latch;
    nvalid = 0;
    nlatch = 0;
    prev_latch = latch6;
    for (int k = 0; k < 4; k++) vat[k] = -1;
    poll6 = 1'b1;
    p0 = cyc;
    for (int i = 1; i <= 329; i++) begin
      @(negedge clk);
      n = cyc - p0;
      if (valid6) begin
        if (nvalid < 4) vat[nvalid] = n;
        nvalid++;
      end
      if (latch6 && !prev_latch) nlatch++;
      prev_latch = latch6;
    end
    poll6 = 1'b0;
    vecs++;
    if (nvalid != 3) begin
      errs++;
      $display("FAIL b2b_valid_count: got %0d expected 3", nvalid);
    end
    vecs++;
    if (nlatch != 3) begin
      errs++;
      $display("FAIL b2b_latch_pulses: got %0d expected 3", nlatch);
    end
    vecs++;
    if (vat[0] != 109 || vat[1] != 219 || vat[2] != 329) begin
      errs++;
      $display("FAIL b2b_valid_cycles: got %0d,%0d,%0d expected 109,219,329", vat[0], vat[1], vat[2]);
    end
    @(negedge clk);
    vecs++;
    if (busy6 !== 1'b0) begin
      errs++;
      $display("FAIL b2b_idle_after: got busy %b expected 0", busy6);
    end
  endtask

  task automatic test_reset_mid_poll();
    int p0, at;
    bit ok;
    btn6_1_B = 8'h5A;
    btn6_2_B = 8'h0F;
    start6(p0);
    repeat (39) @(negedge clk);
    vecs++;
    if (cyc - p0 != 40 || busy6 !== 1'b1) begin
      errs++;
      $display("FAIL mid_busy_at40: got cycle %0d busy %b expected 40/1", cyc - p0, busy6);
    end
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if ({latch6, cclk6, cen6, valid6, busy6, b6_1, b6_2} !== 21'h0) begin
      errs++;
      $display("FAIL mid_reset_values: got %h expected 000000", {latch6, cclk6, cen6, valid6, busy6, b6_1, b6_2});
    end
    rst = 1'b0;
    start6(p0);
    wait_valid6(p0, 200, at, ok);
    vecs++;
    if (!ok || at != 109) begin
      errs++;
      $display("FAIL mid_repoll_cycle: got %0d expected 109", at);
    end
    vecs++;
    if (b6_1 !== 8'hA5 || b6_2 !== 8'hF0) begin
      errs++;
      $display("FAIL mid_repoll_buttons: got %h/%h expected A5/F0", b6_1, b6_2);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_button_change();
    int p0, at;
    bit ok, stable;
    btn6_1_B = 8'hFE;
    btn6_2_B = 8'hFF;
    start6(p0);
    wait_valid6(p0, 200, at, ok);
    vecs++;
    if (!ok || b6_1 !== 8'h01) begin
      errs++;
      $display("FAIL change_first: got %h expected 01", b6_1);
    end
    btn6_1_B = 8'hFF;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (b6_1 !== 8'h01) stable = 1'b0;
    end
    start6(p0);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (valid6) begin
        ok = 1'b1;
        at = cyc - p0;
      end else begin
        if (b6_1 !== 8'h01) stable = 1'b0;
        @(negedge clk);
      end
    end
    vecs++;
    if (stable !== 1'b1) begin
      errs++;
      $display("FAIL change_stable: got stable %b expected 1", stable);
    end
    vecs++;
    if (!ok || at != 109 || b6_1 !== 8'h00) begin
      errs++;
      $display("FAIL change_second: got %h at %0d expected 00 at 109", b6_1, at);
    end
  endtask

  initial begin
    test_reset();
    test_poll_async();
    test_poll_sync();
    test_half_period_one();
    test_back_to_back();
    test_reset_mid_poll();
    test_button_change();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
